collect: RTL and testbench
==========================

// Module: collect
// PURPOSE
//  Downstream consumer for the dispatch traffic source in latency-constraint examples.
//  Accepts a valid/ready stream with a pseudo-random backpressure pattern.
//  Accumulates a 32-bit signature over accepted data, counts beats, lp beats and stalls.
//  Checks i_lp against the data it arrived with.
//  Raises o_done after NBEATS accepted beats, so a bench can compare o_sig with a golden value.
// PARAMETERS
//  WIDTH        8         data width, 4..32 (lp check uses bits [3:0])
//  NBEATS       64        accepted beats per run, 1..65535
//  RDY_PATTERN  16'hC3A5  backpressure pattern, rotated right once per RUN cycle
// PORTS
//  clk          in   1      clock
//  reset        in   1      asynchronous, active-high reset
//  i_start      in   1      start pulse: IDLE->RUN, or DONE->RUN with clear
//  i_valid      in   1      upstream data valid
//  o_ready      out  1      sink ready
//  i_data       in   WIDTH  upstream data
//  i_lp         in   1      upstream lp flag, travels with i_data
//  o_done       out  1      level: run complete (state DONE)
//  o_sig        out  32     running signature
//  o_beats      out  16     accepted beat count
//  o_lp_beats   out  16     accepted beats with i_lp=1
//  o_stalls     out  16     RUN cycles with i_valid=1, o_ready=0; saturates at 16'hFFFF
//  o_error      out  1      sticky: some accepted i_lp != f(i_data)
// BEHAVIOUR
//  Reset values: state=IDLE, pat=RDY_PATTERN, o_sig=0, all counters 0, o_error=0.
//    o_done=0 and o_ready=0.
//  States:
//    IDLE: on i_start go to RUN.
//    RUN:  i_start ignored. Go to DONE on the accept that makes beats==NBEATS.
//    DONE: on i_start clear sig, counters and error, reload pat, and go to RUN.
//  o_ready = (state==RUN) & pat[0], combinational from registers, never from i_valid.
//  pat rotates right ({pat[0],pat[15:1]}) every RUN cycle. It is frozen in IDLE and DONE.
//  accept = i_valid & o_ready. A transfer needs no other qualifier.
//    i_data and i_lp are ignored when no accept occurs.
//  On accept:
//    sig <= {sig[30:0],sig[31]} ^ {{(32-WIDTH){1'b0}},i_data}
//    beats += 1
//    lp_beats += i_lp
//  lp check: f(d) = (d[0]&d[1]) | (d[2]^d[3]). Set o_error on an accept with i_lp != f(i_data).
//  All outputs except o_ready are registered. They update the cycle after the causing event.
//    o_done rises the cycle after the final accept, with o_ready=0 in that cycle.
//  In DONE the sink accepts nothing. Upstream must hold its data (standard valid/ready).
//  i_start in the same cycle as the final RUN accept: the accept counts; i_start is ignored.
//  Reset mid-run: every register returns to its reset value immediately (async).
// TESTING
//  1 WIDTH=8, NBEATS=4, RDY_PATTERN=16'hFFFF, i_start, i_valid=1, data 01,02,03,04, lp=0,0,1,1
//    -> o_sig=32'h2, o_beats=4, o_lp_beats=2, o_stalls=0, o_error=0, o_done=1
//  2 Test 1 with RDY_PATTERN=16'h5555
//    -> o_ready=1,0,1,0,1,0,1; 4 accepts over 7 RUN cycles; o_stalls=3; o_sig=32'h2
//  3 Test 1 with lp on 8'h03 driven 0
//    -> o_error=1 and stays 1 until the next i_start; o_lp_beats=1
//  4 i_valid=1 in IDLE with no i_start for 10 cycles
//    -> o_ready=0, all counters 0; then i_start -> first accept the cycle after entering RUN
//  5 In DONE, hold i_valid=1 and pulse i_start
//    -> counters, sig and error clear; pat reloads; a new run of NBEATS completes
//  6 Assert reset after 2 accepts of a 4-beat run
//    -> all outputs return to reset values; IDLE until i_start

Source files
------------

// File: rtl/collect.sv
// -----------------------------------------------------------------------------
// collect
//   Downstream consumer for a valid/ready traffic source. A rotating 16-bit
//   pattern drives o_ready while running, giving a repeatable backpressure
//   profile. Accepted data is folded into a 32-bit rotate/xor signature.
//   Accepted beats, beats flagged lp, and stalled cycles are counted. Every
//   accepted lp flag is checked against a fixed function of its data. o_done
//   rises once NBEATS beats have been accepted.
//
// Handshake: a beat transfers on any rising clk edge where i_valid and
//   o_ready are both high, with no other qualifier. o_ready depends only on
//   registered state, never on i_valid. Upstream holds i_data/i_lp stable
//   while i_valid is high and o_ready is low. i_data and i_lp are ignored
//   on cycles without a transfer.
//
// Ports
//   clk          in   1      clock
//   reset        in   1      asynchronous, active-high reset
//   i_start      in   1      start pulse: IDLE->RUN, or DONE->RUN with clear
//   i_valid      in   1      upstream data valid
//   o_ready      out  1      sink ready
//   i_data       in   WIDTH  upstream data
//   i_lp         in   1      upstream lp flag, travels with i_data
//   o_done       out  1      level: run complete
//   o_sig        out  32     running signature
//   o_beats      out  16     accepted beat count
//   o_lp_beats   out  16     accepted beats with i_lp=1
//   o_stalls     out  16     RUN cycles with i_valid=1, o_ready=0 (saturating)
//   o_error      out  1      sticky: some accepted i_lp != f(i_data)
// -----------------------------------------------------------------------------
module collect #(
    parameter int          WIDTH       = 8,
    parameter int          NBEATS      = 64,
    parameter logic [15:0] RDY_PATTERN = 16'hC3A5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_lp,
    output logic             o_done,
    output logic [31:0]      o_sig,
    output logic [15:0]      o_beats,
    output logic [15:0]      o_lp_beats,
    output logic [15:0]      o_stalls,
    output logic             o_error
);

    localparam logic [15:0] LAST_BEAT = 16'(NBEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pat;
    logic        accept;
    logic        lp_expect;
    logic [31:0] data_ext;

    assign o_ready  = (state == RUN) & pat[0];
    assign accept   = i_valid & o_ready;
    // Zero-extend through a cast so WIDTH=32 needs no zero-length replication.
    assign data_ext = 32'(i_data);
    assign lp_expect = (i_data[0] & i_data[1]) | (i_data[2] ^ i_data[3]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pat        <= RDY_PATTERN;
            o_done     <= 1'b0;
            o_sig      <= 32'd0;
            o_beats    <= 16'd0;
            o_lp_beats <= 16'd0;
            o_stalls   <= 16'd0;
            o_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state <= RUN;
                        pat   <= RDY_PATTERN;
                    end
                end

                RUN: begin
                    // i_start is deliberately ignored here, even on the final accept.
                    pat <= {pat[0], pat[15:1]};
                    if (i_valid && !pat[0] && (o_stalls != 16'hFFFF)) begin
                        o_stalls <= o_stalls + 16'd1;
                    end
                    if (accept) begin
                        o_sig      <= {o_sig[30:0], o_sig[31]} ^ data_ext;
                        o_beats    <= o_beats + 16'd1;
                        o_lp_beats <= o_lp_beats + 16'(i_lp);
                        if (i_lp != lp_expect) begin
                            o_error <= 1'b1;
                        end
                        if ((o_beats + 16'd1) == LAST_BEAT) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // pat stays frozen until a restart reloads it.
                    if (i_start) begin
                        state      <= RUN;
                        pat        <= RDY_PATTERN;
                        o_done     <= 1'b0;
                        o_sig      <= 32'd0;
                        o_beats    <= 16'd0;
                        o_lp_beats <= 16'd0;
                        o_stalls   <= 16'd0;
                        o_error    <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collect.sv
// -----------------------------------------------------------------------------
// tb_collect
//   Three collect instances share one input stream: a 4-beat sink that is
//   always ready, a 4-beat sink with alternating readiness, and a 64-beat sink
//   with the default pattern. A behavioural model predicts every output; the
//   signature is recomputed from the queue of accepted data in closed form.
// -----------------------------------------------------------------------------
module tb_collect;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       lp;

    logic [N-1:0]       ready_w;
    logic [N-1:0]       done_w;
    logic [N-1:0]       err_w;
    logic [N-1:0][31:0] sig_w;
    logic [N-1:0][15:0] beats_w;
    logic [N-1:0][15:0] lpb_w;
    logic [N-1:0][15:0] stall_w;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    collect #(.WIDTH(8), .NBEATS(4), .RDY_PATTERN(16'hFFFF)) u_full (
        .clk(clk), .reset(reset), .i_start(start), .i_valid(valid),
        .o_ready(ready_w[0]), .i_data(data), .i_lp(lp), .o_done(done_w[0]),
        .o_sig(sig_w[0]), .o_beats(beats_w[0]), .o_lp_beats(lpb_w[0]),
        .o_stalls(stall_w[0]), .o_error(err_w[0])
    );

    collect #(.WIDTH(8), .NBEATS(4), .RDY_PATTERN(16'h5555)) u_half (
        .clk(clk), .reset(reset), .i_start(start), .i_valid(valid),
        .o_ready(ready_w[1]), .i_data(data), .i_lp(lp), .o_done(done_w[1]),
        .o_sig(sig_w[1]), .o_beats(beats_w[1]), .o_lp_beats(lpb_w[1]),
        .o_stalls(stall_w[1]), .o_error(err_w[1])
    );

    collect #(.WIDTH(8), .NBEATS(64), .RDY_PATTERN(16'hC3A5)) u_dflt (
        .clk(clk), .reset(reset), .i_start(start), .i_valid(valid),
        .o_ready(ready_w[2]), .i_data(data), .i_lp(lp), .o_done(done_w[2]),
        .o_sig(sig_w[2]), .o_beats(beats_w[2]), .o_lp_beats(lpb_w[2]),
        .o_stalls(stall_w[2]), .o_error(err_w[2])
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;

    int          m_mode   [N];   // 0 idle, 1 running, 2 complete
    int          m_k      [N];   // cycles spent running since (re)start
    logic [15:0] m_beats  [N];
    logic [15:0] m_lpb    [N];
    logic [15:0] m_stalls [N];
    logic        m_err    [N];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nb_of(input int i);
        case (i)
            0:       return 4;
            1:       return 4;
            default: return 64;
        endcase
    endfunction

    function automatic logic [15:0] pat_of(input int i);
        case (i)
            0:       return 16'hFFFF;
            1:       return 16'h5555;
            default: return 16'hC3A5;
        endcase
    endfunction

    // Readiness in running cycle k is bit (k mod 16) of the pattern.
    function automatic logic m_ready(input int i);
        logic [15:0] p;
        p = pat_of(i);
        return (m_mode[i] == 1) && p[4'(m_k[i] % 16)];
    endfunction

    function automatic logic lp_rule(input logic [7:0] d);
        int v;
        v = int'(d);
        return ((v % 4) == 3) || (((v / 4) % 2) != ((v / 8) % 2));
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
        if (r == 0) return x;
        return (x << r) | (x >> (32 - r));
    endfunction

    // Signature in closed form: beat j of n is rotated left (n-1-j) places.
    function automatic logic [31:0] m_sig(input int i);
        logic [31:0] q[$];
        logic [31:0] s;
        case (i)
            0:       q = exp_q0;
            1:       q = exp_q1;
            default: q = exp_q2;
        endcase
        s = 32'd0;
        for (int j = 0; j < q.size(); j++) begin
            s = s ^ rotl(q[j], (q.size() - 1 - j) % 32);
        end
        return s;
    endfunction

    task automatic m_clear(input int i);
        m_beats[i]  = 16'd0;
        m_lpb[i]    = 16'd0;
        m_stalls[i] = 16'd0;
        m_err[i]    = 1'b0;
        case (i)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_k[i]    = 0;
            m_clear(i);
        end
    endtask

    task automatic m_push(input int i, input logic [31:0] d);
        case (i)
            0:       exp_q0.push_back(d);
            1:       exp_q1.push_back(d);
            default: exp_q2.push_back(d);
        endcase
    endtask

    // Advance instance i across one clock edge using the current inputs.
    task automatic model_edge(input int i);
        logic rdy;
        if (m_mode[i] == 0) begin
            if (start) begin
                m_mode[i] = 1;
                m_k[i]    = 0;
            end
        end else if (m_mode[i] == 1) begin
            rdy = m_ready(i);
            if (valid && !rdy && m_stalls[i] != 16'hFFFF) m_stalls[i] = m_stalls[i] + 16'd1;
            if (valid && rdy) begin
                m_push(i, 32'(data));
                m_beats[i] = m_beats[i] + 16'd1;
                if (lp) m_lpb[i] = m_lpb[i] + 16'd1;
                if (lp != lp_rule(data)) m_err[i] = 1'b1;
                if (int'(m_beats[i]) == nb_of(i)) m_mode[i] = 2;
            end
            m_k[i] = m_k[i] + 1;
        end else begin
            if (start) begin
                m_clear(i);
                m_mode[i] = 1;
                m_k[i]    = 0;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            check($sformatf("done[%0d]", i),   32'(done_w[i]),  32'(m_mode[i] == 2));
            check($sformatf("sig[%0d]", i),    sig_w[i],        m_sig(i));
            check($sformatf("beats[%0d]", i),  32'(beats_w[i]), 32'(m_beats[i]));
            check($sformatf("lpb[%0d]", i),    32'(lpb_w[i]),   32'(m_lpb[i]));
            check($sformatf("stalls[%0d]", i), 32'(stall_w[i]), 32'(m_stalls[i]));
            check($sformatf("error[%0d]", i),  32'(err_w[i]),   32'(m_err[i]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set just after a rising edge; ready is compared on the falling
    // edge, registered outputs 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("ready[%0d]", i), 32'(ready_w[i]), 32'(m_ready(i)));
        end
        if (reset) m_reset();
        else for (int i = 0; i < N; i++) model_edge(i);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Reset raised between edges must take effect without a clock edge.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_ready[%0d]", i), 32'(ready_w[i]), 32'd0);
        end
        check_outputs();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic lpt [4];
    int   idx;
    int   runs;
    logic acc;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        data  = 8'd0;
        lp    = 1'b0;
        m_reset();
        #1;
        check_outputs();
        tick();
        tick();
        reset = 1'b0;

        // Valid in IDLE without a start: nothing moves.
        valid = 1'b1;
        for (int n = 0; n < 10; n++) begin
            data = 8'($urandom);
            tick();
        end
        check("idle_beats", 32'(beats_w[0]), 32'd0);

        // Always-ready run of 01..04 with lp 0,0,1,1.
        lpt[0] = 1'b0; lpt[1] = 1'b0; lpt[2] = 1'b1; lpt[3] = 1'b1;
        pulse_start();
        for (int j = 0; j < 4; j++) begin
            data = 8'(j + 1);
            lp   = lpt[j];
            tick();
            check("t1_beats_step", 32'(beats_w[0]), 32'(j + 1));
        end
        check("t1_sig",    sig_w[0],           32'h2);
        check("t1_beats",  32'(beats_w[0]),    32'd4);
        check("t1_lpb",    32'(lpb_w[0]),      32'd2);
        check("t1_stalls", 32'(stall_w[0]),    32'd0);
        check("t1_error",  32'(err_w[0]),      32'd0);
        check("t1_done",   32'(done_w[0]),     32'd1);

        // Complete: hold valid, nothing is accepted; then restart clears.
        data = 8'h55;
        lp   = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        check("t5_hold_beats", 32'(beats_w[0]), 32'd4);
        pulse_start();
        check("t5_clr_beats", 32'(beats_w[0]), 32'd0);
        check("t5_clr_sig",   sig_w[0],        32'd0);

        // Same run with lp on 03 wrong.
        lpt[2] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            data = 8'(j + 1);
            lp   = lpt[j];
            tick();
        end
        check("t3_error", 32'(err_w[0]), 32'd1);
        check("t3_lpb",   32'(lpb_w[0]), 32'd1);
        check("t3_sig",   sig_w[0],      32'h2);
        for (int n = 0; n < 3; n++) tick();
        check("t3_sticky", 32'(err_w[0]), 32'd1);
        pulse_start();
        check("t3_cleared", 32'(err_w[0]), 32'd0);

        // Alternating readiness: data held until the 5555 sink takes it.
        async_reset();
        lpt[2] = 1'b1;
        pulse_start();
        idx  = 0;
        runs = 0;
        for (int n = 0; n < 20 && idx < 4; n++) begin
            data = 8'(idx + 1);
            lp   = lpt[idx];
            acc  = m_ready(1);
            tick();
            runs++;
            if (acc) idx++;
        end
        check("t2_accepts", 32'(idx),        32'd4);
        check("t2_cycles",  32'(runs),       32'd7);
        check("t2_stalls",  32'(stall_w[1]), 32'd3);
        check("t2_sig",     sig_w[1],        32'h2);
        check("t2_done",    32'(done_w[1]),  32'd1);

        // Reset after two accepts of a 4-beat run.
        async_reset();
        pulse_start();
        for (int j = 0; j < 2; j++) begin
            data = 8'(j + 1);
            lp   = lpt[j];
            tick();
        end
        check("t6_beats_pre", 32'(beats_w[0]), 32'd2);
        async_reset();
        for (int n = 0; n < 5; n++) tick();
        check("t6_beats_post", 32'(beats_w[0]), 32'd0);

        // Randomised traffic, starts and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            start = ($urandom_range(0, 39) == 0);
            valid = ($urandom_range(0, 9) < 7);
            data  = 8'($urandom);
            lp    = ($urandom_range(0, 7) == 0) ? ~lp_rule(data) : lp_rule(data);
            if ($urandom_range(0, 499) == 0) async_reset();
            tick();
        end
        start = 1'b0;
        valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
